// File: rtl/pipe_out_credit_fifo.sv
// pipe_out_credit_fifo
// Credit-gated output FIFO placed behind a valid-only pipeline that cannot be
// back-pressured. A launch into the pipeline is allowed only while a credit is
// free. One credit covers one word, either still in flight in the pipeline or
// already held in the FIFO, so every result the pipeline returns has a slot.
// The credit comes back when the consumer pops that word.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   issue_valid/_ready  upstream launch handshake (ready = credit available)
//   in_data/in_valid    pipeline result, always accepted when there is room
//   out_data/_valid/_ready  registered FIFO head to the consumer
//   occupancy       number of words stored in the FIFO
//   overflow_err    sticky flag: a pipeline result arrived with no room
module pipe_out_credit_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0]      credits;
  logic [CNT_W-1:0]      occ;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic issue_fire;
  logic out_fire;
  logic full;
  logic wr_en;
  logic drop;

  assign issue_ready = (credits != '0);
  assign issue_fire  = issue_valid & issue_ready;
  assign out_valid   = (occ != '0);
  assign out_fire    = out_valid & out_ready;
  assign full        = (occ == FULL_CNT);
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign wr_en       = in_valid & (~full | out_fire);
  assign drop        = in_valid & full & ~out_fire;
  assign out_data    = mem[rd_ptr];
  assign occupancy   = occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= FULL_CNT;
    end else begin
      case ({issue_fire, out_fire})
        2'b10:   credits <= credits - 1'b1;
        // Saturate: a pop of a word that was never issued (a misbehaving
        // pipeline) must not mint credits beyond DEPTH.
        2'b01:   if (credits != FULL_CNT) credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else begin
      case ({wr_en, out_fire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)    wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (out_fire) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       overflow_err <= 1'b0;
    else if (drop) overflow_err <= 1'b1;
  end

endmodule
